// File: rtl/comparator_pkg.sv
// Shared encodings for the registered magnitude comparator.
// The flag vector is always ordered {G, Eq, L}.
package comparator_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    function automatic logic [2:0] cmp_pack(
        input logic gt,
        input logic eq,
        input logic lt
    );
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// One-bit cascade cell of the MSB-first magnitude chain.
// A decision already made above passes through; otherwise this bit decides.
module comparator_slice
    import comparator_pkg::*;
(
    input  logic ai,
    input  logic bi,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_out,
    output logic eq_out,
    output logic lt_out
);

    always_comb begin
        gt_out = gt_in | (eq_in & ai & ~bi);
        lt_out = lt_in | (eq_in & ~ai & bi);
        eq_out = eq_in & ~(ai ^ bi);
    end

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator: {G,Eq,L} one-hot, one cycle after sampling.
// Unsigned or two's-complement, evaluated by an MSB-to-LSB slice chain.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             enable,
    output logic             G,
    output logic             Eq,
    output logic             L
);

    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] eq_c;
    logic [WIDTH:0] lt_c;
    logic [2:0]     flags;

    assign gt_c[WIDTH] = 1'b0;
    assign eq_c[WIDTH] = 1'b1;
    assign lt_c[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        logic sa;
        logic sb;
        // A set sign bit means the smaller value, so swap operands on the MSB
        localparam bit SWAP = (SIGNED != 0) && (i == WIDTH - 1);
        assign sa = SWAP ? b[i] : a[i];
        assign sb = SWAP ? a[i] : b[i];

        comparator_slice u_slice (
            .ai     (sa),
            .bi     (sb),
            .gt_in  (gt_c[i+1]),
            .eq_in  (eq_c[i+1]),
            .lt_in  (lt_c[i+1]),
            .gt_out (gt_c[i]),
            .eq_out (eq_c[i]),
            .lt_out (lt_c[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= CMP_NONE;
        end else if (enable) begin
            flags <= cmp_pack(gt_c[0], eq_c[0], lt_c[0]);
        end else begin
            flags <= CMP_NONE;
        end
    end

    assign G  = flags[2];
    assign Eq = flags[1];
    assign L  = flags[0];

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench: 1-bit unsigned, 8-bit unsigned and 8-bit signed
// comparators driven together, results checked through a scoreboard queue.
module tb_comparator;

    typedef struct {
        string      tag;
        logic [2:0] e1;
        logic [2:0] eu;
        logic [2:0] es;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       g1, q1, l1;
    logic       gu, qu, lu;
    logic       gs, qs, ls;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    comparator u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .enable(enable),
        .G(g1), .Eq(q1), .L(l1)
    );

    comparator #(.WIDTH(8), .SIGNED(0)) u8u (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .enable(enable),
        .G(gu), .Eq(qu), .L(lu)
    );

    comparator #(.WIDTH(8), .SIGNED(1)) u8s (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .enable(enable),
        .G(gs), .Eq(qs), .L(ls)
    );

    function automatic logic [2:0] model(
        input logic r, input logic en, input int x, input int y
    );
        if (!r || !en) return 3'b000;
        if (x > y)     return 3'b100;
        if (x == y)    return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string tag, input logic [2:0] got,
                         input logic [2:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, compare after the edge
    task automatic step(input logic r, input logic en,
                        input logic xa, input logic xb,
                        input logic [7:0] ya, input logic [7:0] yb,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        enable = en;
        a1 = xa; b1 = xb;
        a8 = ya; b8 = yb;
        e.tag = tag;
        e.e1  = model(r, en, int'(xa), int'(xb));
        e.eu  = model(r, en, int'(ya), int'(yb));
        e.es  = model(r, en, int'($signed(ya)), int'($signed(yb)));
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "/w1"},  {g1, q1, l1}, e.e1);
        check({e.tag, "/w8u"}, {gu, qu, lu}, e.eu);
        check({e.tag, "/w8s"}, {gs, qs, ls}, e.es);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;

        step(0, 1, 1, 0, 8'h01, 8'h00, "reset0");
        step(0, 1, 1, 0, 8'h01, 8'h00, "reset1");
        step(1, 1, 1, 0, 8'h01, 8'h00, "release");

        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            ab = 2'(k);
            for (int n = 0; n < 3; n++)
                step(1, 1, ab[1], ab[0], 8'h10, 8'h20, "sweep");
        end

        step(1, 1, 1, 0, 8'h7F, 8'h80, "en_hi");
        step(1, 0, 1, 0, 8'h7F, 8'h80, "en_lo");
        step(1, 1, 1, 0, 8'h7F, 8'h80, "en_back");

        step(1, 1, 1, 0, 8'h00, 8'hFF, "b2b_10");
        step(1, 1, 0, 1, 8'h80, 8'h7F, "b2b_01");
        step(1, 1, 1, 1, 8'hA5, 8'hA5, "b2b_11");
        step(1, 1, 0, 0, 8'hFF, 8'h00, "b2b_00");

        step(1, 1, 1, 0, 8'hFF, 8'hFF, "pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hold_w1",  {g1, q1, l1}, 3'b100);
        check("midrst_hold_w8s", {gs, qs, ls}, 3'b010);
        @(posedge clk);
        #1;
        check("midrst_clr_w1",  {g1, q1, l1}, 3'b000);
        check("midrst_clr_w8u", {gu, qu, lu}, 3'b000);
        step(1, 1, 0, 1, 8'h00, 8'hFF, "post_rst");

        step(1, 1, 0, 0, 8'hFF, 8'h00, "max_0");
        step(1, 1, 0, 0, 8'h80, 8'h81, "neg_neg");
        step(1, 1, 0, 0, 8'h01, 8'h02, "pos_pos");

        for (int n = 0; n < 20; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (n % 5 == 0) ? ra : 8'($urandom);
            step(1, 1, ra[0], rb[0], ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
